// File: rtl/alu_pkg.sv
// Shared ALU encodings: 4-bit ALU control words, control-field positions and
// the serial sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
  localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

  localparam int AINV  = 3;
  localparam int BINV  = 2;
  localparam int OP_HI = 1;
  localparam int OP_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Overflow is only meaningful for the two true arithmetic operations.
  function automatic logic is_arith(input logic [3:0] ctrl);
    return (ctrl == ALU_CTRL_ADD) || (ctrl == ALU_CTRL_SUB);
  endfunction

endpackage

// File: rtl/alu_top.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add/less select.
// set carries the adder sum out of the MSB slice for SLT.
module alu_top (
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       result,
  output logic       cout,
  output logic       set
);

  logic aa;
  logic bb;
  logic sum;

  assign aa   = a ^ a_invert;
  assign bb   = b ^ b_invert;
  assign sum  = aa ^ bb ^ cin;
  assign cout = (aa & bb) | (cin & (aa ^ bb));
  assign set  = sum;

  always_comb begin
    unique case (op)
      2'b00:   result = aa & bb;
      2'b01:   result = aa | bb;
      2'b10:   result = sum;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: runs one alu_top slice across a WIDTH-bit word,
// LSB first, with the inter-bit carry held in a register.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       ctrl_reg;
  logic             carry;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] final_word;
  logic             slice_res;
  logic             slice_cout;
  logic             slice_set;

  alu_top u_slice (
    .a        (a_reg[idx]),
    .b        (b_reg[idx]),
    .less     (1'b0),
    .a_invert (ctrl_reg[AINV]),
    .b_invert (ctrl_reg[BINV]),
    .cin      (carry),
    .op       (ctrl_reg[OP_HI:OP_LO]),
    .result   (slice_res),
    .cout     (slice_cout),
    .set      (slice_set)
  );

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (idx == LAST_IDX) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Word as it will look once the MSB bit lands; SLT replaces bit 0 with the
  // raw sign of A-B taken from the MSB slice.
  always_comb begin
    final_word             = shadow;
    final_word[WIDTH-1]    = slice_res;
    if (ctrl_reg[OP_HI:OP_LO] == 2'b11) final_word[0] = slice_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      ctrl_reg <= '0;
      carry    <= 1'b0;
      shadow   <= '0;
      result   <= '0;
      zero     <= 1'b0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= src1;
            b_reg    <= src2;
            ctrl_reg <= ctrl;
            carry    <= ctrl[BINV];
            shadow   <= '0;
            idx      <= '0;
          end
        end
        RUN: begin
          shadow[idx] <= slice_res;
          carry       <= slice_cout;
          if (idx == LAST_IDX) begin
            // Publish the whole word at once so result never shows a partial value.
            result   <= final_word;
            zero     <= ~|final_word;
            cout     <= slice_cout;
            overflow <= is_arith(ctrl_reg) & (carry ^ slice_cout);
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == FIN);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl: arithmetic/logic vectors, latency,
// ignored mid-run starts and reset abandoning an operation.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  int lat;
  int done_after;
  int busy_gap;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ctrl     (ctrl),
    .src1     (src1),
    .src2     (src2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .cout     (cout),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done. lat counts negedge
  // samples after the accepting edge, so the 33rd one is the done cycle.
  // With poke set, start is re-pulsed with junk operands at cycles 5 and 20.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    @(negedge clk);
    ctrl = c; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk);
    lat = 0;
    busy_gap = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (poke && (cyc == 5 || cyc == 20)) begin
        start = 1'b1; ctrl = ALU_CTRL_SUB; src1 = 32'h1234_5678; src2 = 32'h0BAD_F00D;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = cyc;
        break;
      end
      if (!busy) busy_gap++;
    end
    start = 1'b0;
    @(negedge clk);
    done_after = int'(done);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ctrl = 4'b0; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_flags", {29'd0, zero, cout, overflow}, 32'd0);
    rst_n = 1'b1;

    run_op(ALU_CTRL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check("add_latency", 32'(lat), 32'd33);
    check("add_busy_gap", 32'(busy_gap), 32'd0);
    check("add_done_pulse", 32'(done_after), 32'd0);
    check("add_result", result, 32'h8000_0000);
    check("add_flags zc_ov", {29'd0, zero, cout, overflow}, {29'd0, 1'b0, 1'b0, 1'b1});

    run_op(ALU_CTRL_SUB, 32'd5, 32'd5, 1'b0);
    check("sub_eq_result", result, 32'h0);
    check("sub_eq_flags", {29'd0, zero, cout, overflow}, {29'd0, 1'b1, 1'b1, 1'b0});

    run_op(ALU_CTRL_SUB, 32'h8000_0000, 32'd1, 1'b0);
    check("sub_ovf_result", result, 32'h7FFF_FFFF);
    check("sub_ovf_flags", {29'd0, zero, cout, overflow}, {29'd0, 1'b0, 1'b1, 1'b1});

    run_op(ALU_CTRL_SLT, 32'd3, 32'd7, 1'b0);
    check("slt_3_7", result, 32'h1);
    check("slt_3_7_ovf", 32'(overflow), 32'd0);
    run_op(ALU_CTRL_SLT, 32'd7, 32'd3, 1'b0);
    check("slt_7_3", result, 32'h0);
    check("slt_7_3_zero", 32'(zero), 32'd1);
    run_op(ALU_CTRL_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("slt_m1_1", result, 32'h1);
    check("slt_m1_1_zero", 32'(zero), 32'd0);

    // ~(F0F0F0F0 | 0F0F0F00) = ~FFFFFFF0
    run_op(ALU_CTRL_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F00, 1'b0);
    check("nor_result", result, 32'h0000_000F);
    check("nor_zero", 32'(zero), 32'd0);
    run_op(ALU_CTRL_AND, 32'hF0F0_F0F0, 32'h0F0F_0F00, 1'b0);
    check("and_result", result, 32'h0);
    check("and_zero", 32'(zero), 32'd1);
    run_op(ALU_CTRL_OR, 32'hF0F0_F0F0, 32'h0F0F_0F00, 1'b0);
    check("or_result", result, 32'hFFFF_FFF0);
    check("or_ovf", 32'(overflow), 32'd0);

    // Starts during RUN are ignored: operands stay captured, one done pulse.
    run_op(ALU_CTRL_ADD, 32'd100, 32'd23, 1'b1);
    check("poke_latency", 32'(lat), 32'd33);
    check("poke_busy_gap", 32'(busy_gap), 32'd0);
    check("poke_done_pulse", 32'(done_after), 32'd0);
    check("poke_result", result, 32'd123);
    check("poke_idle_after", 32'(busy), 32'd0);

    // Reset one edge into RUN cycle 10 abandons the operation.
    @(negedge clk);
    ctrl = ALU_CTRL_ADD; src1 = 32'd9; src2 = 32'd9; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'h0);
    check("midrst_flags", {29'd0, zero, cout, overflow}, 32'd0);
    repeat (25) @(negedge clk);
    check("midrst_no_done", 32'(done), 32'd0);

    run_op(ALU_CTRL_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("post_rst_latency", 32'(lat), 32'd33);
    check("post_rst_result", result, 32'h0);
    check("post_rst_flags", {29'd0, zero, cout, overflow}, {29'd0, 1'b1, 1'b1, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
